// File: rtl/cam_capture_rgb111.sv
// Camera capture front end: samples an RGB565 byte stream from an asynchronous pixel clock,
// reduces each pixel to RGB111 and writes it into a frame buffer RAM.
module cam_capture_rgb111 #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 3,
   parameter int unsigned IMG_W = 16,
   parameter int unsigned IMG_H = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cam_pclk,
   input  logic          cam_vsync,
   input  logic          cam_href,
   input  logic [7:0]    cam_data,
   input  logic          capture_en,
   output logic [AW-1:0] DP_RAM_addr_in,
   output logic [DW-1:0] DP_RAM_data_in,
   output logic          DP_RAM_regW,
   output logic          frame_done,
   output logic          busy
);

   localparam int unsigned CW = $clog2(IMG_W + 1);
   localparam int unsigned RW = $clog2(IMG_H + 1);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H);
   localparam logic [AW-1:0] IMG_W_A = AW'(IMG_W);

   typedef enum logic [1:0] {StIdle, StSync, StCapture} state_e;

   state_e        state_q;
   logic [2:0]    pclk_sync, vsync_sync, href_sync;
   logic [2:0]    data_s1;
   logic [1:0]    hi_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic          phase_q, line_pix_q;

   // Only R (bit 7), G (bit 2) and B (bit 4) survive the RGB111 reduction.
   logic unused_data;
   assign unused_data = ^{cam_data[6:5], cam_data[3], cam_data[1:0]};

   // [0] first stage, [1] synchronized level, [2] previous synchronized level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pclk_sync  <= '0;
         vsync_sync <= '0;
         href_sync  <= '0;
         data_s1    <= '0;
      end else begin
         pclk_sync  <= {pclk_sync[1:0], cam_pclk};
         vsync_sync <= {vsync_sync[1:0], cam_vsync};
         href_sync  <= {href_sync[1:0], cam_href};
         data_s1    <= {cam_data[7], cam_data[4], cam_data[2]};
      end
   end

   logic pclk_evt, vs_fall, vs_rise, href_fall, href_act, pix_done;
   logic [AW-1:0] wr_addr;

   assign pclk_evt  = pclk_sync[1] & ~pclk_sync[2];
   assign vs_fall   = vsync_sync[2] & ~vsync_sync[1];
   assign vs_rise   = vsync_sync[1] & ~vsync_sync[2];
   assign href_fall = href_sync[2] & ~href_sync[1];
   // A byte arriving together with the href falling edge still belongs to the line.
   assign href_act  = href_sync[1] | href_sync[2];
   assign pix_done  = pclk_evt & href_act & phase_q;
   assign wr_addr   = AW'(row_q) * IMG_W_A + AW'(col_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= StIdle;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         DP_RAM_regW    <= 1'b0;
         DP_RAM_addr_in <= '0;
         DP_RAM_data_in <= '0;
         hi_q           <= '0;
         col_q          <= '0;
         row_q          <= '0;
         phase_q        <= 1'b0;
         line_pix_q     <= 1'b0;
      end else begin
         DP_RAM_regW <= 1'b0;
         frame_done  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (capture_en) begin
                  state_q <= StSync;
                  busy    <= 1'b1;
               end
            end
            StSync: begin
               if (vs_fall) begin
                  state_q    <= StCapture;
                  col_q      <= '0;
                  row_q      <= '0;
                  phase_q    <= 1'b0;
                  line_pix_q <= 1'b0;
               end
            end
            StCapture: begin
               if (vs_rise) begin
                  frame_done <= 1'b1;
                  state_q    <= capture_en ? StSync : StIdle;
                  busy       <= capture_en;
               end else begin
                  if (pclk_evt && href_act) begin
                     if (!phase_q) begin
                        hi_q    <= {data_s1[2], data_s1[0]};
                        phase_q <= 1'b1;
                     end else begin
                        phase_q    <= 1'b0;
                        line_pix_q <= 1'b1;
                        if (col_q < COL_MAX && row_q < ROW_MAX) begin
                           DP_RAM_regW    <= 1'b1;
                           DP_RAM_addr_in <= wr_addr;
                           DP_RAM_data_in <= DW'({hi_q[1], hi_q[0], data_s1[1]});
                           col_q          <= col_q + 1'b1;
                        end
                     end
                  end
                  // Line end overrides the pixel update above when both occur together.
                  if (href_fall) begin
                     col_q      <= '0;
                     phase_q    <= 1'b0;
                     line_pix_q <= 1'b0;
                     if ((line_pix_q || pix_done) && row_q < ROW_MAX) row_q <= row_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
